// File: rtl/fibo_stream_checker_if.sv
// ---------------------------------------------------------------------------
// fibo_stream_checker_if
//
// Purpose
//   Handshake bundle between a Fibonacci stream generator and its checker.
//   The generator presents a value with fib_valid.
//   The checker pulls the next value by raising adv.
//   A value is transferred on a rising clock edge where fib_valid && adv.
//   While fib_valid && !adv, the generator holds fib_in stable.
//
// Parameters
//   W          data width of fib_in
//
// Signals
//   fib_valid  generator -> checker   fib_in carries a value this cycle
//   fib_in     generator -> checker   W-bit stream value
//   adv        checker   -> generator ready/advance
//
// Modports
//   master     generator side (drives fib_valid/fib_in, observes adv)
//   slave      checker side   (observes fib_valid/fib_in, drives adv)
// ---------------------------------------------------------------------------
interface fibo_stream_checker_if #(
  parameter int W = 8
) ();

  logic         fib_valid;
  logic [W-1:0] fib_in;
  logic         adv;

  modport master (
    output fib_valid,
    output fib_in,
    input  adv
  );

  modport slave (
    input  fib_valid,
    input  fib_in,
    output adv
  );

endinterface

// File: rtl/fibo_stream_checker.sv
// ---------------------------------------------------------------------------
// fibo_stream_checker
//
// Purpose
//   Consumer end of a Fibonacci stream.
//   It drives the generator's advance bit and samples each accepted W-bit
//   value. Each value is checked against the recurrence
//       f(0) = SEED0, f(1) = SEED1, f(n) = f(n-1) + f(n-2) mod 2^W
//   A run of N values ends with pass/fail, a saturating error count and the
//   index/value of the first failure. These results serve self-checking
//   regressions.
//
// Parameters
//   W       data width; the recurrence wraps mod 2^W
//   N       number of values checked per run (N >= 2)
//   SEED0   expected value at index 0
//   SEED1   expected value at index 1
//   CW      err_count width; err_count saturates at 2^CW-1
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run. It is honoured in IDLE, DONE and FAULT.
//                   It is ignored in RUN.
//   fib        slave modport of fibo_stream_checker_if. It carries
//              fib_valid, fib_in and adv.
//   mismatch   out  one-cycle pulse on the cycle after a failed compare
//   done       out  run finished (level)
//   pass       out  valid while done; 1 = no mismatch in this run
//   err_count  out  mismatches in this run, saturating
//   bad_index  out  index of the first mismatch
//   bad_value  out  received value at the first mismatch
//
// Configuration macro
//   FIBO_CHK_RESYNC_EN
//     defined   : A mismatch does not end the run. The expected-value pipeline
//                 already follows the received values, so checking
//                 resynchronises and continues to N. pass is 0 if any
//                 mismatch was seen.
//     undefined : The first mismatch moves the checker to FAULT
//                 (done=1, pass=0). The run ends there.
// ---------------------------------------------------------------------------
module fibo_stream_checker #(
  parameter int  W     = 8,
  parameter int  N     = 16,
  parameter int  SEED0 = 0,
  parameter int  SEED1 = 1,
  parameter int  CW    = 4,
  localparam int IW    = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  fibo_stream_checker_if.slave   fib,
  output logic                   mismatch,
  output logic                   done,
  output logic                   pass,
  output logic [CW-1:0]          err_count,
  output logic [IW-1:0]          bad_index,
  output logic [W-1:0]           bad_value
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [CW-1:0] ERR_MAX  = '1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N);
  localparam logic [W-1:0]  SEED0_V  = W'(SEED0);
  localparam logic [W-1:0]  SEED1_V  = W'(SEED1);

  state_t         state_q,     state_d;
  logic [IW-1:0]  idx_q,       idx_d;
  logic [W-1:0]   exp_a_q,     exp_a_d;      // value two accepts back
  logic [W-1:0]   exp_b_q,     exp_b_d;      // most recently accepted value
  logic           mismatch_q,  mismatch_d;
  logic           done_q,      done_d;
  logic           pass_q,      pass_d;
  logic [CW-1:0]  err_count_q, err_count_d;
  logic [IW-1:0]  bad_index_q, bad_index_d;
  logic [W-1:0]   bad_value_q, bad_value_d;

  logic           accept;
  logic           miss;
  logic [W-1:0]   exp_value;

  // The first two indices come from the seeds. Every later index is the
  // W-bit sum of the last two received values. The carry out is dropped on
  // purpose, because the stream is defined mod 2^W.
  always_comb begin
    exp_value = exp_a_q + exp_b_q;
    if (idx_q == '0) begin
      exp_value = SEED0_V;
    end else if (idx_q == IW'(1)) begin
      exp_value = SEED1_V;
    end
  end

  assign accept = (state_q == ST_RUN) && fib.fib_valid;
  assign miss   = accept && (fib.fib_in != exp_value);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    exp_a_d     = exp_a_q;
    exp_b_d     = exp_b_q;
    mismatch_d  = 1'b0;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    bad_index_d = bad_index_q;
    bad_value_d = bad_value_q;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          // The history always tracks what was received, not what was
          // expected. This lets a resync build recover after one bad value.
          exp_a_d = exp_b_q;
          exp_b_d = fib.fib_in;
          idx_d   = idx_q + IW'(1);

          if (miss) begin
            mismatch_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + CW'(1);
            end
            // A zero count means this is the first failure of the run.
            // Saturation never wraps the count back to zero, so the test
            // stays valid.
            if (err_count_q == '0) begin
              bad_index_d = idx_q;
              bad_value_d = fib.fib_in;
            end
          end

`ifdef FIBO_CHK_RESYNC_EN
          if (idx_d == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end
`else
          if (miss) begin
            state_d = ST_FAULT;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end else if (idx_d == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0);
          end
`endif
        end
      end

      // IDLE, DONE and FAULT behave the same way. Results hold until a new
      // run is started.
      default: begin
        if (start) begin
          state_d     = ST_RUN;
          idx_d       = '0;
          exp_a_d     = '0;
          exp_b_d     = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_count_d = '0;
          bad_index_d = '0;
          bad_value_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      exp_a_q     <= '0;
      exp_b_q     <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      bad_index_q <= '0;
      bad_value_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      exp_a_q     <= exp_a_d;
      exp_b_q     <= exp_b_d;
      mismatch_q  <= mismatch_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      bad_index_q <= bad_index_d;
      bad_value_q <= bad_value_d;
    end
  end

  // adv is decoded straight from the state register. It therefore drops on
  // the same cycle that done rises.
  assign fib.adv   = (state_q == ST_RUN);

  assign mismatch  = mismatch_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign bad_index = bad_index_q;
  assign bad_value = bad_value_q;

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Two checkers share clk/rst: u_a (N=10) and u_b (N=16, wrap test).
// A reference model in the bench tracks each run from the received history.
// The model is checked against every DUT output once per cycle, at 1 time
// unit after the clock edge. Hand-computed literal checks pin the key results.
module tb_fibo_stream_checker;

`ifdef FIBO_CHK_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic a_start, b_start;
  logic a_mm, a_done, a_pass, b_mm, b_done, b_pass;
  logic [3:0] a_err, b_err;
  logic [3:0] a_bidx;
  logic [4:0] b_bidx;
  logic [7:0] a_bval, b_bval;

  int n_checks = 0;
  int n_errors = 0;
  int mm_seen_a = 0;
  int mm_seen_b = 0;

  always #5 clk = ~clk;

  fibo_stream_checker_if #(.W(8)) if_a ();
  fibo_stream_checker_if #(.W(8)) if_b ();

  fibo_stream_checker #(.W(8), .N(10), .SEED0(0), .SEED1(1), .CW(4)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .fib(if_a),
    .mismatch(a_mm), .done(a_done), .pass(a_pass),
    .err_count(a_err), .bad_index(a_bidx), .bad_value(a_bval)
  );

  fibo_stream_checker #(.W(8), .N(16), .SEED0(0), .SEED1(1), .CW(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .fib(if_b),
    .mismatch(b_mm), .done(b_done), .pass(b_pass),
    .err_count(b_err), .bad_index(b_bidx), .bad_value(b_bval)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 running, 2 finished ok/with errors, 3 faulted
  int NK [2] = '{10, 16};
  int m_phase [2];
  int m_cnt   [2];
  int m_hist  [2][64];
  int m_err   [2];
  int m_bidx  [2];
  int m_bval  [2];
  int m_mm    [2];
  int m_done  [2];
  int m_pass  [2];

  task automatic model_step(input int k, input bit r, input bit st, input bit v, input int d);
    int e;
    m_mm[k] = 0;
    if (r) begin
      m_phase[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_bidx[k] = 0;
      m_bval[k] = 0; m_done[k] = 0; m_pass[k] = 0;
      return;
    end
    if (m_phase[k] == 1) begin
      if (v) begin
        if (m_cnt[k] == 0)      e = 0;
        else if (m_cnt[k] == 1) e = 1;
        else e = (m_hist[k][m_cnt[k]-1] + m_hist[k][m_cnt[k]-2]) % 256;
        if (d != e) begin
          m_mm[k] = 1;
          if (m_err[k] == 0) begin
            m_bidx[k] = m_cnt[k];
            m_bval[k] = d;
          end
          if (m_err[k] < 15) m_err[k] = m_err[k] + 1;
        end
        m_hist[k][m_cnt[k]] = d;
        m_cnt[k] = m_cnt[k] + 1;
        if (m_mm[k] == 1 && !RESYNC) begin
          m_phase[k] = 3; m_done[k] = 1; m_pass[k] = 0;
        end else if (m_cnt[k] == NK[k]) begin
          m_phase[k] = 2; m_done[k] = 1; m_pass[k] = (m_err[k] == 0) ? 1 : 0;
        end
      end
    end else if (st) begin
      m_phase[k] = 1; m_cnt[k] = 0; m_err[k] = 0; m_bidx[k] = 0;
      m_bval[k] = 0; m_done[k] = 0; m_pass[k] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, required %0d", name, $time, act, exp);
    end
  endtask

  // One compare process: update the model on the edge, then check outputs.
  always @(posedge clk) begin
    model_step(0, rst, a_start, if_a.fib_valid, int'(if_a.fib_in));
    model_step(1, rst, b_start, if_b.fib_valid, int'(if_b.fib_in));
    #1;
    check("a.adv",  int'(if_a.adv), (m_phase[0] == 1) ? 1 : 0);
    check("a.mismatch", int'(a_mm), m_mm[0]);
    check("a.done", int'(a_done), m_done[0]);
    check("a.pass", int'(a_pass), m_pass[0]);
    check("a.err_count", int'(a_err), m_err[0]);
    check("a.bad_index", int'(a_bidx), m_bidx[0]);
    check("a.bad_value", int'(a_bval), m_bval[0]);
    check("b.adv",  int'(if_b.adv), (m_phase[1] == 1) ? 1 : 0);
    check("b.mismatch", int'(b_mm), m_mm[1]);
    check("b.done", int'(b_done), m_done[1]);
    check("b.pass", int'(b_pass), m_pass[1]);
    check("b.err_count", int'(b_err), m_err[1]);
    check("b.bad_index", int'(b_bidx), m_bidx[1]);
    check("b.bad_value", int'(b_bval), m_bval[1]);
    if (a_mm) mm_seen_a++;
    if (b_mm) mm_seen_b++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int k, input bit v, input int d);
    if (k == 0) begin
      if_a.fib_valid = v; if_a.fib_in = 8'(d);
    end else begin
      if_b.fib_valid = v; if_b.fib_in = 8'(d);
    end
  endtask

  function automatic bit cur_adv(input int k);
    return (k == 0) ? if_a.adv : if_b.adv;
  endfunction

  task automatic send(input int k, input int d);
    int t;
    t = 0;
    @(negedge clk);
    drive(k, 1'b1, d);
    while (!cur_adv(k) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout inst=%0d value=%0d: adv never rose, required adv=1", k, d);
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int k, input int n);
    @(negedge clk);
    drive(k, 1'b0, 0);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk);
    if (k == 0) a_start = 1'b1; else b_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  int fib10 [10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
  int fib16 [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
  int bad5  [5]  = '{0, 1, 1, 2, 4};
  int cont5 [5]  = '{6, 10, 16, 26, 42};
  int mm0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    drive(0, 1'b0, 0);
    drive(1, 1'b0, 0);
    repeat (3) @(negedge clk);
    // Reset state
    check("rst.a.adv", int'(if_a.adv), 0);
    check("rst.a.done", int'(a_done), 0);
    check("rst.a.err", int'(a_err), 0);
    check("rst.b.done", int'(b_done), 0);
    rst = 1'b0;

    // T1: clean run on u_a
    pulse_start(0);
    for (int i = 0; i < 10; i++) send(0, fib10[i]);
    @(negedge clk);
    drive(0, 1'b0, 0);
    check("T1.done", int'(a_done), 1);
    check("T1.pass", int'(a_pass), 1);
    check("T1.err", int'(a_err), 0);
    check("T1.adv_low", int'(if_a.adv), 0);

    // T2: wrap-around on u_b (233 + 144 -> 121, 121 + 233 -> 98)
    mm0 = mm_seen_b;
    pulse_start(1);
    for (int i = 0; i < 16; i++) send(1, fib16[i]);
    @(negedge clk);
    drive(1, 1'b0, 0);
    check("T2.done", int'(b_done), 1);
    check("T2.pass", int'(b_pass), 1);
    check("T2.err", int'(b_err), 0);
    check("T2.mm_pulses", mm_seen_b - mm0, 0);

    // T3: corrupted index 4
    mm0 = mm_seen_a;
    pulse_start(0);
    for (int i = 0; i < 5; i++) send(0, bad5[i]);
    idle(0, 2);
    check("T3.bad_index", int'(a_bidx), 4);
    check("T3.bad_value", int'(a_bval), 4);
    check("T3.err", int'(a_err), 1);
    check("T3.mm_pulses", mm_seen_a - mm0, 1);
`ifdef FIBO_CHK_RESYNC_EN
    // T4: resync continues the stream to N
    for (int i = 0; i < 5; i++) send(0, cont5[i]);
    idle(0, 1);
    check("T4.done", int'(a_done), 1);
    check("T4.pass", int'(a_pass), 0);
    check("T4.err", int'(a_err), 1);
    check("T4.mm_pulses", mm_seen_a - mm0, 1);
`else
    check("T3.fault_adv", int'(if_a.adv), 0);
    check("T3.fault_done", int'(a_done), 1);
    check("T3.fault_pass", int'(a_pass), 0);
`endif

    // T5: fib_valid dropped for 3 cycles at index 5
    mm0 = mm_seen_a;
    pulse_start(0);
    for (int i = 0; i < 5; i++) send(0, fib10[i]);
    idle(0, 3);
    check("T5.adv_hold", int'(if_a.adv), 1);
    check("T5.done_low", int'(a_done), 0);
    for (int i = 5; i < 10; i++) send(0, fib10[i]);
    idle(0, 1);
    check("T5.done", int'(a_done), 1);
    check("T5.pass", int'(a_pass), 1);
    check("T5.mm_pulses", mm_seen_a - mm0, 0);

    // T6: rst at index 6, then rerun with a start pulse during RUN
    pulse_start(0);
    for (int i = 0; i < 6; i++) send(0, fib10[i]);
    @(negedge clk);
    drive(0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("T6.rst_adv", int'(if_a.adv), 0);
    check("T6.rst_done", int'(a_done), 0);
    check("T6.rst_pass", int'(a_pass), 0);
    check("T6.rst_err", int'(a_err), 0);
    check("T6.rst_bidx", int'(a_bidx), 0);
    check("T6.rst_bval", int'(a_bval), 0);
    check("T6.rst_b_done", int'(b_done), 0);
    pulse_start(0);
    for (int i = 0; i < 3; i++) send(0, fib10[i]);
    idle(0, 0);
    pulse_start(0);
    check("T6.start_in_run", int'(if_a.adv), 1);
    for (int i = 3; i < 10; i++) send(0, fib10[i]);
    idle(0, 1);
    check("T6.done", int'(a_done), 1);
    check("T6.pass", int'(a_pass), 1);
    check("T6.err", int'(a_err), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
